// File: rtl/roll_pkg.sv
// Shared definitions for the roll sequencer: FSM state encoding and the
// default generator constants used by the sequencer and the display top level.
package roll_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } roll_state_e;

    localparam int unsigned ROLL_A    = 9;
    localparam int unsigned ROLL_B    = 15;
    localparam int unsigned ROLL_SEED = 0;

endpackage

// File: rtl/lcg_core.sv
// Linear congruential generator register: x' = (A*x + B) mod 2**WIDTH,
// advanced only when i_en is high. o_next exposes x' for the same-edge capture.
module lcg_core #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned A     = 9,
    parameter int unsigned B     = 15,
    parameter int unsigned SEED  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_state,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] state_q;

    // 64-bit intermediate is congruent mod 2**WIDTH, so truncation is exact.
    always_comb begin
        o_next = WIDTH'(64'(A) * 64'(state_q) + 64'(B));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WIDTH'(SEED);
        end else if (i_en) begin
            state_q <= o_next;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/roll_sequencer.sv
// Roll sequencer: steps the LCG with a linearly growing gap between steps,
// ends after NUM_STEPS steps or on i_stop, and keeps the final value.
module roll_sequencer
    import roll_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned A         = ROLL_A,
    parameter int unsigned B         = ROLL_B,
    parameter int unsigned SEED      = ROLL_SEED,
    parameter int unsigned NUM_STEPS = 16,
    parameter int unsigned GAP_INC   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_random_out,
    output logic [WIDTH-1:0] o_last_out,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned StepW  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned GapMax = GAP_INC * (NUM_STEPS - 1);
    localparam int unsigned GapW   = (GapMax > 0) ? $clog2(GapMax + 1) : 1;
    localparam logic [StepW-1:0] LastStep = StepW'(NUM_STEPS - 1);

    roll_state_e      state_q, state_d;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [GapW-1:0]  gap_lim_q, gap_lim_d;
    logic [GapW-1:0]  gap_lim_next;
    logic [WIDTH-1:0] random_q, random_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lcg_en;
    logic [WIDTH-1:0] lcg_state;
    logic [WIDTH-1:0] lcg_next;

    lcg_core #(
        .WIDTH(WIDTH),
        .A    (A),
        .B    (B),
        .SEED (SEED)
    ) u_lcg (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (lcg_en),
        .o_state(lcg_state),
        .o_next (lcg_next)
    );

    assign gap_lim_next = gap_lim_q + GapW'(GAP_INC);

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gap_lim_d  = gap_lim_q;
        random_d   = random_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        lcg_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    step_cnt_d = '0;
                    gap_lim_d  = '0;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    // Abort wins over the step: freeze the displayed value.
                    state_d = S_IDLE;
                    last_d  = random_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lcg_en     = 1'b1;
                    random_d   = lcg_next;
                    step_cnt_d = step_cnt_q + StepW'(1);
                    if (step_cnt_q == LastStep) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        last_d  = lcg_next;
                    end else begin
                        gap_cnt_d = '0;
                        gap_lim_d = gap_lim_next;
                        state_d   = (gap_lim_next == '0) ? S_RUN : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    last_d  = random_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                    if (gap_cnt_q == gap_lim_q - GapW'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
            gap_cnt_q  <= '0;
            gap_lim_q  <= '0;
            random_q   <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_lim_q  <= gap_lim_d;
            random_q   <= random_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The generator state itself is not an output; the registered copy is.
    logic unused_lcg;
    assign unused_lcg = ^lcg_state;

    assign o_random_out = random_q;
    assign o_last_out   = last_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Bench for roll_sequencer (NUM_STEPS=4, GAP_INC=1): a schedule-based model
// checked every cycle, plus hand-computed literal expectations.
module tb_roll_sequencer;

    localparam int unsigned W      = 4;
    localparam int unsigned NSTEPS = 4;
    localparam int unsigned GAPI   = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] rnd;
    logic [W-1:0] last;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    roll_sequencer #(
        .WIDTH    (W),
        .NUM_STEPS(NSTEPS),
        .GAP_INC  (GAPI)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .o_random_out(rnd),
        .o_last_out  (last),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Model: x persists across rolls; step k lands k+1+GAPI*k*(k+1)/2 edges after start.
    int m_x, m_rand, m_last, m_t, m_k;
    int m_busy, m_done;

    function automatic int land_edge(input int k);
        return k + 1 + GAPI * k * (k + 1) / 2;
    endfunction

    task automatic model_reset();
        m_x = 0; m_rand = 0; m_last = 0; m_t = 0; m_k = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (m_busy == 0) begin
            if (start) begin
                m_busy = 1; m_t = 0; m_k = 0;
            end
        end else begin
            m_t++;
            if (stop) begin
                m_last = m_rand; m_busy = 0; m_done = 1;
            end else if (m_t == land_edge(m_k)) begin
                m_x    = (9 * m_x + 15) % (1 << W);
                m_rand = m_x;
                m_k++;
                if (m_k == NSTEPS) begin
                    m_busy = 0; m_done = 1; m_last = m_rand;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("random_out", int'(rnd), m_rand);
        chk("last_out", int'(last), m_last);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_random", int'(rnd), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no start
        repeat (6) cyc();
        chk("idle_busy", int'(busy), 0);
        chk("idle_random", int'(rnd), 0);

        // Full roll from SEED: 15@e1, 6@e3, 5@e6, 12@e10
        start = 1'b1; cyc(); start = 1'b0;
        chk("e0_busy", int'(busy), 1);
        for (int e = 1; e <= 10; e++) begin
            cyc();
            if (e == 1) chk("e1_value", int'(rnd), 15);
            if (e == 3) chk("e3_value", int'(rnd), 6);
            if (e == 6) chk("e6_value", int'(rnd), 5);
            if (e == 9) chk("e9_hold", int'(rnd), 5);
        end
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        chk("end_last", int'(last), 12);

        // Start accepted in the done cycle; LCG continues: 11, 2, 1, 8
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_done_low", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        cyc();
        chk("roll2_first", int'(rnd), 11);
        repeat (10) cyc();
        chk("roll2_last", int'(last), 8);
        repeat (2) cyc();

        // Async reset mid-gap (roll 3: 7@e1, 14@e3)
        start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();
        chk("roll3_e4", int'(rnd), 14);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_random", int'(rnd), 0);
        chk("async_last", int'(last), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh roll after reset, stop while in gap after e3
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("reseed_e1", int'(rnd), 15);
        cyc(); cyc();
        chk("stop_pre_e3", int'(rnd), 6);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_hold", int'(rnd), 6);
        chk("stop_last", int'(last), 6);
        chk("stop_done", int'(done), 1);
        chk("stop_busy", int'(busy), 0);
        repeat (4) cyc();
        chk("stop_frozen", int'(rnd), 6);

        // Start pulses while busy are ignored: 5@e1, 12@e3, 11@e6, 2@e10
        start = 1'b1; cyc(); start = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            start = ((e % 2) == 0) && (e < 8);
            cyc();
            if (e == 3) chk("busy_start_e3", int'(rnd), 12);
            if (e == 6) chk("busy_start_e6", int'(rnd), 11);
            if (e == 10) chk("busy_start_last", int'(last), 2);
        end
        start = 1'b0;

        // Start and stop together while busy act as a stop (x=2 -> 1@e1)
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("both_e1", int'(rnd), 1);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("both_last", int'(last), 1);
        chk("both_done", int'(done), 1);
        cyc();
        chk("both_idle", int'(busy), 0);

        // Stop during the run cycle beats the step (x=1 -> 8@e1, stop before e3)
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("run_stop_e1", int'(rnd), 8);
        cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("run_stop_hold", int'(rnd), 8);
        chk("run_stop_last", int'(last), 8);
        repeat (2) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("no_step_on_stop", int'(rnd), 7);
        repeat (12) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
